// File: rtl/ram_dp_param_pkg.sv
// Shared definitions for the parametrised dual-port RAM: clear FSM states,
// read-during-write mode codes and register-bank offsets.
package ram_dp_param_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Register bank lives in the top four words, counted down from DEPTH-1.
  localparam int REG_A_OFS = 0;
  localparam int REG_B_OFS = 1;
  localparam int REG_C_OFS = 2;
  localparam int REG_D_OFS = 3;

  function automatic int reg_index(input int depth, input int ofs);
    return depth - 1 - ofs;
  endfunction

endpackage

// File: rtl/ram_dp_param_if.sv
// Bus bundle for ram_dp_param: user write/read request side plus read result and busy.
interface ram_dp_param_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) ();
  logic                  write;
  logic                  read;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  read_valid;
  logic                  busy;

  modport master (
    output write, read, write_addr, read_addr, data_in,
    input  data_out, read_valid, busy
  );

  modport slave (
    input  write, read, write_addr, read_addr, data_in,
    output data_out, read_valid, busy
  );
endinterface

// File: rtl/ram_dp_param_clear_seq.sv
// Post-reset clear sequencer: walks every address once, one word per cycle,
// and holds busy while doing so.
module ram_dp_param_clear_seq
  import ram_dp_param_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  busy
);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clr_addr_d = '0;
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        // Stop on the last word rather than relying on the counter wrapping.
        if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_addr_d = '0;
      end
    endcase
  end

  assign clr_addr = clr_addr_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: rtl/ram_dp_param.sv
// Simple-dual-port synchronous RAM with selectable read-during-write behaviour,
// optional output register, read_valid tag and hardware clear after reset.
module ram_dp_param
  import ram_dp_param_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 6,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          reset,
  ram_dp_param_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  busy;

  ram_dp_param_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  assign bus.busy = busy;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  user_we;
  logic                  rd_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    user_we = bus.write && !busy && !reset;
    rd_en   = bus.read && !busy && !reset;
    if (clr_we) begin
      mem_we    = !reset;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else begin
      mem_we    = user_we;
      mem_waddr = bus.write_addr;
      mem_wdata = bus.data_in;
    end
    // Write-first mode forwards the incoming word around the array.
    if ((RDW_MODE == RDW_WRITE_FIRST) && user_we && (bus.write_addr == bus.read_addr)) begin
      rd_word = bus.data_in;
    end else begin
      rd_word = mem_q[bus.read_addr];
    end
    rd_valid_d = rd_en;
    if (rd_en) begin
      rd_data_d = rd_word;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q;

    always_comb begin
      if (rd_valid_q) begin
        out_data_d = rd_data_q;
      end else begin
        out_data_d = out_data_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_data_q  <= out_data_d;
        out_valid_q <= rd_valid_q;
      end
    end

    assign bus.data_out   = out_data_q;
    assign bus.read_valid = out_valid_q;
  end else begin : g_no_out_reg
    assign bus.data_out   = rd_data_q;
    assign bus.read_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_ram_dp_param.sv
// Bench for ram_dp_param: two configurations (16x64 read-first, 1-cycle; 32x256
// write-first, 2-cycle) driven in lockstep and compared against an array model.
module tb_ram_dp_param;
  import ram_dp_param_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_dp_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) ifa ();
  ram_dp_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) ifb ();

  ram_dp_param #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  ram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int total = 0;
  int bad   = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int          depth [2] = '{64, 256};
  int          lat   [2] = '{1, 2};
  int          rdw   [2] = '{0, 1};
  logic [31:0] mask  [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
  logic [31:0] mm    [2][256];
  int          clr_left [2];
  bit          due_v [2][4096];
  logic [31:0] due_d [2][4096];
  logic [31:0] last  [2];
  bit          exp_v [2];
  int          busy_cnt [2];
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input int d, input bit rst, input bit w, input bit r,
                            input logic [7:0] wa, input logic [7:0] ra, input logic [31:0] din);
    int          aw;
    int          ar;
    bit          idle;
    logic [31:0] wv;
    logic [31:0] val;
    aw   = int'(wa) % depth[d];
    ar   = int'(ra) % depth[d];
    idle = (clr_left[d] == 0);
    wv   = din & mask[d];
    if (rst) begin
      for (int k = 0; k < 4; k++) due_v[d][cyc+k] = 1'b0;
      last[d]     = 32'h0;
      clr_left[d] = depth[d];
      for (int i = 0; i < 256; i++) mm[d][i] = 32'h0;
    end else begin
      if (idle && r) begin
        val = (rdw[d] == 1 && w && aw == ar) ? wv : mm[d][ar];
        due_v[d][cyc+lat[d]-1] = 1'b1;
        due_d[d][cyc+lat[d]-1] = val;
      end
      if (idle && w) mm[d][aw] = wv;
      if (clr_left[d] > 0) clr_left[d]--;
    end
    exp_v[d] = due_v[d][cyc];
    if (exp_v[d]) last[d] = due_d[d][cyc];
  endtask

  task automatic step(input bit rst, input bit w, input bit r,
                      input logic [7:0] wa, input logic [7:0] ra, input logic [31:0] din);
    reset          = rst;
    ifa.write      = w;
    ifa.read       = r;
    ifa.write_addr = wa[5:0];
    ifa.read_addr  = ra[5:0];
    ifa.data_in    = din[15:0];
    ifb.write      = w;
    ifb.read       = r;
    ifb.write_addr = wa;
    ifb.read_addr  = ra;
    ifb.data_in    = din;
    @(posedge clk);
    model_edge(0, rst, w, r, wa, ra, din);
    model_edge(1, rst, w, r, wa, ra, din);
    cyc++;
    #1;
    chk("busy_a",  {31'h0, ifa.busy},       {31'h0, clr_left[0] != 0});
    chk("valid_a", {31'h0, ifa.read_valid}, {31'h0, exp_v[0]});
    chk("dout_a",  {16'h0, ifa.data_out},   last[0]);
    chk("busy_b",  {31'h0, ifb.busy},       {31'h0, clr_left[1] != 0});
    chk("valid_b", {31'h0, ifb.read_valid}, {31'h0, exp_v[1]});
    chk("dout_b",  ifb.data_out,            last[1]);
    if (ifa.busy === 1'b1) busy_cnt[0]++;
    if (ifb.busy === 1'b1) busy_cnt[1]++;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((ifa.busy !== 1'b0 || ifb.busy !== 1'b0) && n < budget) begin
      idle_step();
      n++;
    end
    chk("idle_timeout", {31'h0, ifa.busy | ifb.busy}, 32'h0);
  endtask

  initial begin
    logic [7:0]  wa;
    logic [7:0]  ra;
    logic [31:0] din;
    bit          w;
    bit          r;
    int          reg_a;

    // T1: reset, clear length, then every low address reads zero.
    busy_cnt = '{0, 0};
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
    wait_idle(400);
    chk("t1_busy_cycles_a", busy_cnt[0], 32'd64);
    chk("t1_busy_cycles_b", busy_cnt[1], 32'd256);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 8'(i), 32'h0);
    idle_step();
    idle_step();

    // T2: write then read back at the next cycle.
    step(1'b0, 1'b1, 1'b0, 8'd5, 8'd0, 32'h0000_BEEF);
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd5, 32'h0);
    chk("t2_dout_a", {16'h0, ifa.data_out}, 32'h0000_BEEF);
    idle_step();
    chk("t2_dout_b", ifb.data_out, 32'h0000_BEEF);
    idle_step();

    // T3: same-address read and write in one cycle.
    step(1'b0, 1'b1, 1'b0, 8'd9, 8'd0, 32'h0000_1111);
    step(1'b0, 1'b1, 1'b1, 8'd9, 8'd9, 32'h0000_2222);
    chk("t3_read_first_a", {16'h0, ifa.data_out}, 32'h0000_1111);
    idle_step();
    chk("t3_write_first_b", ifb.data_out, 32'h0000_2222);
    idle_step();

    // Random traffic with frequent address collisions.
    for (int i = 0; i < 300; i++) begin
      w   = 1'($urandom_range(0, 1));
      r   = 1'($urandom_range(0, 1));
      wa  = 8'($urandom_range(0, 255));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255));
      din = $urandom;
      step(1'b0, w, r, wa, ra, din);
    end
    idle_step();
    idle_step();

    // T4: accesses during clear are ignored.
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
    step(1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 32'h0000_ABCD);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 32'h0);
    wait_idle(400);
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd3, 32'h0);
    chk("t4_dout_a", {16'h0, ifa.data_out}, 32'h0);
    idle_step();
    chk("t4_dout_b", ifb.data_out, 32'h0);

    // T5: reset reasserted during clear restarts it.
    busy_cnt = '{0, 0};
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
    for (int i = 0; i < 20; i++) idle_step();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 32'h0);
    wait_idle(400);
    chk("t5_busy_cycles_a", busy_cnt[0], 32'd85);
    chk("t5_busy_cycles_b", busy_cnt[1], 32'd277);

    // T6: register bank on the wide instance, streaming reads.
    reg_a = reg_index(256, REG_A_OFS);
    step(1'b0, 1'b1, 1'b0, 8'(reg_index(256, REG_C_OFS)), 8'd0, 32'h0000_0011);
    step(1'b0, 1'b1, 1'b0, 8'(reg_index(256, REG_B_OFS)), 8'd0, 32'h0000_0022);
    step(1'b0, 1'b1, 1'b0, 8'(reg_a), 8'd0, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd253, 32'h0);
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd254, 32'h0);
    chk("t6_dout_b_253", ifb.data_out, 32'h0000_0011);
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd255, 32'h0);
    chk("t6_dout_b_254", ifb.data_out, 32'h0000_0022);
    idle_step();
    chk("t6_dout_b_255", ifb.data_out, 32'hDEAD_BEEF);
    chk("t6_valid_b_255", {31'h0, ifb.read_valid}, 32'h1);
    idle_step();
    chk("t6_valid_b_end", {31'h0, ifb.read_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
